// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    localparam int         ALU_OP_W = 3;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;

    // One-hot class vector bit positions, MSB first: {r, ori, lui, lw, sw, beq, jal, jr, nop}
    localparam int CLS_W   = 9;
    localparam int CLS_R   = 8;
    localparam int CLS_ORI = 7;
    localparam int CLS_LUI = 6;
    localparam int CLS_LW  = 5;
    localparam int CLS_SW  = 4;
    localparam int CLS_BEQ = 3;
    localparam int CLS_JAL = 2;
    localparam int CLS_JR  = 1;
    localparam int CLS_NOP = 0;

endpackage

// File: rtl/instr_class_dec.sv
// rtl/instr_class_dec.sv - instruction word to one-hot class; anything unsupported is nop
module instr_class_dec
    import ctrl_pkg::*;
(
    input  logic [31:0]      instr,
    output logic [CLS_W-1:0] cls
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;

    assign opcode            = instr[31:26];
    assign funct             = instr[5:0];
    assign unused_instr_bits = ^instr[25:6];

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU) cls[CLS_R]  = 1'b1;
                else if (funct == FN_JR)                  cls[CLS_JR] = 1'b1;
            end
            OP_ORI:  cls[CLS_ORI] = 1'b1;
            OP_LUI:  cls[CLS_LUI] = 1'b1;
            OP_LW:   cls[CLS_LW]  = 1'b1;
            OP_SW:   cls[CLS_SW]  = 1'b1;
            OP_BEQ:  cls[CLS_BEQ] = 1'b1;
            OP_JAL:  cls[CLS_JAL] = 1'b1;
            default: cls = '0;
        endcase
        if (cls == '0) cls[CLS_NOP] = 1'b1;
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - IF/ID/EX/MEM/WB sequencer driving datapath selects and enables
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instr,
    input  logic                zero,
    output logic                ir_wr,
    output logic                pc_wr,
    output logic [1:0]          npc_sel,
    output logic                jr_flag,
    output logic [1:0]          reg_dst_sel,
    output logic [1:0]          wd_sel,
    output logic                alu_b_sel,
    output logic                ext_sign,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_wr,
    output logic                mem_wr,
    output logic                retire
);

    logic [CLS_W-1:0] cls;
    state_t           state_q;
    state_t           state_d;

    instr_class_dec u_dec (
        .instr (instr),
        .cls   (cls)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        ir_wr       = 1'b0;
        pc_wr       = 1'b0;
        npc_sel     = SEL_A;
        jr_flag     = 1'b0;
        reg_dst_sel = SEL_A;
        wd_sel      = SEL_A;
        alu_b_sel   = 1'b0;
        ext_sign    = 1'b0;
        alu_op      = ALU_OP_W'(ALU_ADD);
        reg_wr      = 1'b0;
        mem_wr      = 1'b0;
        retire      = 1'b0;

        case (state_q)
            S_IF: begin
                ir_wr   = 1'b1;
                pc_wr   = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                state_d = S_EX;
                if (cls[CLS_JAL]) begin
                    pc_wr       = 1'b1;
                    npc_sel     = SEL_C;
                    reg_wr      = 1'b1;
                    reg_dst_sel = SEL_C;
                    wd_sel      = SEL_C;
                    retire      = 1'b1;
                    state_d     = S_IF;
                end else if (cls[CLS_JR]) begin
                    pc_wr   = 1'b1;
                    npc_sel = SEL_C;
                    jr_flag = 1'b1;
                    retire  = 1'b1;
                    state_d = S_IF;
                end else if (cls[CLS_NOP]) begin
                    retire  = 1'b1;
                    state_d = S_IF;
                end
            end
            S_EX: begin
                state_d = S_WB;
                if (cls[CLS_R]) begin
                    alu_op = (instr[5:0] == FN_SUBU) ? ALU_OP_W'(ALU_SUB) : ALU_OP_W'(ALU_ADD);
                end else if (cls[CLS_ORI]) begin
                    alu_b_sel = 1'b1;
                    alu_op    = ALU_OP_W'(ALU_OR);
                end else if (cls[CLS_LUI]) begin
                    alu_b_sel = 1'b1;
                    alu_op    = ALU_OP_W'(ALU_LUI);
                end else if (cls[CLS_LW] || cls[CLS_SW]) begin
                    alu_b_sel = 1'b1;
                    ext_sign  = 1'b1;
                    state_d   = S_MEM;
                end else if (cls[CLS_BEQ]) begin
                    // Branch resolves here: the PC write itself is the taken/not-taken decision
                    alu_op   = ALU_OP_W'(ALU_SUB);
                    pc_wr    = zero;
                    npc_sel  = SEL_B;
                    ext_sign = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_IF;
                end else begin
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                if (cls[CLS_SW]) begin
                    mem_wr  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_IF;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                reg_wr      = 1'b1;
                reg_dst_sel = cls[CLS_R]  ? SEL_B : SEL_A;
                wd_sel      = cls[CLS_LW] ? SEL_B : SEL_A;
                retire      = 1'b1;
                state_d     = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // Reset suppresses every write so an aborted instruction leaves no side effects
        if (reset) begin
            state_d     = S_IF;
            ir_wr       = 1'b0;
            pc_wr       = 1'b0;
            npc_sel     = SEL_A;
            jr_flag     = 1'b0;
            reg_dst_sel = SEL_A;
            wd_sel      = SEL_A;
            alu_b_sel   = 1'b0;
            ext_sign    = 1'b0;
            alu_op      = '0;
            reg_wr      = 1'b0;
            mem_wr      = 1'b0;
            retire      = 1'b0;
        end
    end

endmodule
